uart_upstream_arbiter: RTL

Round-robin scheduler that shares the single UART upstream command channel among `N_PORTS` requesters. Each requester advertises how many words it has ready; the arbiter grants one port at a time. It emits a `{length, port}` header word, then streams exactly that many words from the granted port. The block sits between the on-chip requesters (debug, memory-dump and core-status ports) and the UART router's upstream command input. It replaces fixed-priority, one-word-per-header forwarding with bounded, fair bursts.

---
 rtl/uart_upstream_arbiter_if.sv | 41 ++++
 rtl/uart_upstream_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/uart_upstream_arbiter_if.sv
// Upstream arbitration bus: per-requester pending/payload lanes plus the
// single command channel toward the UART router.
interface uart_upstream_arbiter_if #(
    parameter int unsigned N_PORTS = 4
);
    logic [N_PORTS-1:0][15:0] port_pending_i;
    logic [N_PORTS-1:0][31:0] port_word_i;
    logic [N_PORTS-1:0]       port_valid_i;
    logic [N_PORTS-1:0]       port_ready_o;
    logic [31:0]              command_word_o;
    logic                     command_valid_o;
    logic                     command_ready_i;
    logic                     busy_o;
    logic [3:0]               grant_o;

    // Arbiter side
    modport slave (
        input  port_pending_i,
        input  port_word_i,
        input  port_valid_i,
        output port_ready_o,
        output command_word_o,
        output command_valid_o,
        input  command_ready_i,
        output busy_o,
        output grant_o
    );

    // Requester/router side
    modport master (
        output port_pending_i,
        output port_word_i,
        output port_valid_i,
        input  port_ready_o,
        input  command_word_o,
        input  command_valid_o,
        output command_ready_i,
        input  busy_o,
        input  grant_o
    );
endinterface

// File: rtl/uart_upstream_arbiter.sv
// Round-robin burst scheduler for the UART upstream command channel.
// Each grant emits a {length, port} header, then passes exactly `length`
// words from the granted requester straight through to the router.
module uart_upstream_arbiter #(
    parameter int unsigned N_PORTS   = 4,
    parameter int unsigned MAX_BURST = 16
) (
    input logic                    clk,
    input logic                    reset,
    uart_upstream_arbiter_if.slave bus
);

    localparam int unsigned IDXW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [15:0] MAX_LEN   = 16'(MAX_BURST);
    localparam logic [3:0]  LAST_PORT = 4'(N_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_BURST
    } state_t;

    state_t      r_state;
    logic [3:0]  r_grant;
    logic [3:0]  r_rr_ptr;
    logic [15:0] r_word_cnt;
    logic [15:0] r_burst_len;

    logic            w_found;
    logic [3:0]      w_sel;
    logic [4:0]      w_sum;
    logic [3:0]      w_cand;
    logic [15:0]     w_sel_pend;
    logic [15:0]     w_len;
    logic [IDXW-1:0] w_gidx;
    logic            w_xfer;
    logic [3:0]      w_next_ptr;

    // Pick the first eligible port scanning from the round-robin pointer
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            w_sum = {1'b0, r_rr_ptr} + 5'(i);
            if (w_sum >= 5'(N_PORTS)) begin
                w_sum = w_sum - 5'(N_PORTS);
            end
            w_cand = w_sum[3:0];
            if (!w_found && (bus.port_pending_i[w_cand[IDXW-1:0]] != '0)) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_sel_pend = bus.port_pending_i[w_sel[IDXW-1:0]];
    assign w_len      = (w_sel_pend > MAX_LEN) ? MAX_LEN : w_sel_pend;
    assign w_gidx     = r_grant[IDXW-1:0];
    assign w_xfer     = (r_state == ST_BURST) && bus.port_valid_i[w_gidx]
                        && bus.command_ready_i;
    assign w_next_ptr = (r_grant >= LAST_PORT) ? 4'd0 : r_grant + 4'd1;

    // Grant FSM: arbitrate in IDLE, hold header until accepted, count payload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_word_cnt  <= '0;
            r_burst_len <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_sel;
                        r_burst_len <= w_len;
                        r_word_cnt  <= w_len;
                        r_state     <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (bus.command_ready_i) begin
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_xfer) begin
                        r_word_cnt <= r_word_cnt - 16'd1;
                        if (r_word_cnt == 16'd1) begin
                            r_state  <= ST_IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Header comes from registers; payload and ready pass through unbuffered
    always_comb begin
        bus.command_word_o  = '0;
        bus.command_valid_o = 1'b0;
        bus.port_ready_o    = '0;
        case (r_state)
            ST_HEADER: begin
                bus.command_valid_o = 1'b1;
                bus.command_word_o  = {r_burst_len, 12'd0, r_grant};
            end
            ST_BURST: begin
                bus.command_word_o         = bus.port_word_i[w_gidx];
                bus.command_valid_o        = bus.port_valid_i[w_gidx];
                bus.port_ready_o[w_gidx]   = bus.command_ready_i;
            end
            default: ;
        endcase
    end

    assign bus.busy_o  = (r_state != ST_IDLE);
    assign bus.grant_o = r_grant;

endmodule
